// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmit-port arbiter.
package uart_arb_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } arb_state_e;

  // Width of a requester index; never zero even for a single requester.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request after ptr_i, wrapping modulo NumReq.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdxW = idx_w(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic              any_o,
  output logic [IdxW-1:0]   idx_o
);

  logic [IdxW-1:0] cand;

  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    // ptr_i itself is visited last, so the previous owner has lowest priority.
    for (int unsigned i = 1; i <= NumReq; i++) begin
      cand = IdxW'((32'(ptr_i) + i) % NumReq);
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one UART tx write port, with idle-owner eviction.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       tx_full,
  output logic                       wr_uart,
  output logic [7:0]                 w_data,
  output logic [idx_w(NUM_REQ)-1:0]  owner,
  output logic                       busy,
  output logic                       abort_tick
);

  localparam int unsigned IdxW = idx_w(NUM_REQ);
  localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  arb_state_e           state_q, state_d;
  logic [IdxW-1:0]      owner_q, owner_d;
  logic [IdxW-1:0]      ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 abort_q, abort_d;
  logic                 pick_any;
  logic [IdxW-1:0]      pick_idx;
  logic                 own_valid, own_last, xfer;

  rr_pick #(
    .NumReq(NUM_REQ)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  assign own_valid = req_valid[owner_q];
  assign own_last  = req_last[owner_q];
  assign xfer      = own_valid & ~tx_full;
  assign w_data    = req_data[{owner_q, 3'b000} +: 8];

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    abort_d   = 1'b0;
    req_ready = '0;
    wr_uart   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        req_ready[owner_q] = ~tx_full;
        wr_uart            = xfer;
        if (xfer) begin
          cnt_d = '0;
          if (own_last) begin
            state_d = StIdle;
            ptr_d   = owner_q;
          end
        end else if (!own_valid && !tx_full) begin
          // Only owner silence counts; UART backpressure freezes the counter.
          if (cnt_q == CntLast) begin
            state_d = StIdle;
            ptr_d   = owner_q;
            cnt_d   = '0;
            abort_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (reset) begin
      req_ready = '0;
      wr_uart   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      owner_q <= '0;
      ptr_q   <= IdxW'(NUM_REQ - 1);
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  assign owner      = owner_q;
  assign busy       = (state_q == StBusy);
  assign abort_tick = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter against a cycle-level behavioural model.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int T = 16;

  typedef struct {
    int cyc;
    int own;
    int dat;
  } xfer_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid, req_last, req_ready;
  logic [N*8-1:0]   req_data;
  logic             tx_full, wr_uart, busy, abort_tick;
  logic [7:0]       w_data;
  logic [1:0]       owner;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_full    (tx_full),
    .wr_uart    (wr_uart),
    .w_data     (w_data),
    .owner      (owner),
    .busy       (busy),
    .abort_tick (abort_tick)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Requester packet streams: {last, data}
  bit [8:0] q[N][$];
  int drop_pct = 0;
  int full_pct = 0;
  bit force_full = 0;
  int cyc = 0;
  bit prev_busy = 0;

  xfer_t x_log[$];
  int    g_log[$];
  int    a_log[$];

  // Model: who holds the port, who was served last, how long the holder has been silent.
  bit m_busy;
  int m_owner;
  int m_last_served;
  int m_silent;
  bit m_abort;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input bit [N-1:0] v, input int after);
    for (int j = 1; j <= N; j++)
      if (v[(after + j) % N]) return (after + j) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last_served = N - 1; m_silent = 0; m_abort = 0;
  endtask

  task automatic cycle();
    bit [N-1:0]  v;
    bit [N-1:0]  exp_rdy;
    bit          exp_wr;
    bit [7:0]    exp_d;
    logic [16:0] act, exp;
    int          k;
    for (int i = 0; i < N; i++) begin
      v[i] = (q[i].size() > 0) && ($urandom_range(99) >= drop_pct);
      if (v[i]) {req_last[i], req_data[8*i +: 8]} = q[i][0];
      else begin
        req_last[i] = 1'($urandom_range(1));
        req_data[8*i +: 8] = 8'($urandom_range(255));
      end
    end
    req_valid = v;
    tx_full = force_full | ($urandom_range(99) < full_pct);
    @(negedge clk);
    exp_rdy = '0; exp_wr = 0; exp_d = '0;
    if (m_busy && !reset) begin
      exp_rdy[m_owner] = !tx_full;
      exp_wr = v[m_owner] && !tx_full;
      if (exp_wr) exp_d = req_data[8*m_owner +: 8];
    end
    act = {busy, owner, abort_tick, req_ready, wr_uart, wr_uart ? w_data : 8'h00};
    exp = {m_busy, 2'(m_owner), m_abort, exp_rdy, exp_wr, exp_d};
    check("cycle_outputs{busy,owner,abort,ready,wr,data}", act, exp);
    if (wr_uart) x_log.push_back('{cyc, int'(owner), int'(w_data)});
    if (busy && !prev_busy) g_log.push_back(int'(owner));
    if (abort_tick) a_log.push_back(cyc);
    prev_busy = busy;
    if (reset) model_reset();
    else if (!m_busy) begin
      m_abort = 0;
      k = pick(v, m_last_served);
      if (k >= 0) begin m_busy = 1; m_owner = k; m_silent = 0; end
    end else begin
      m_abort = 0;
      if (exp_wr) begin
        m_silent = 0;
        if (req_last[m_owner]) begin m_busy = 0; m_last_served = m_owner; end
      end else if (!v[m_owner] && !tx_full) begin
        m_silent++;
        if (m_silent == T) begin
          m_busy = 0; m_last_served = m_owner; m_silent = 0; m_abort = 1;
        end
      end
    end
    for (int i = 0; i < N; i++) if (exp_rdy[i] && v[i]) void'(q[i].pop_front());
    cyc++;
    @(posedge clk);
    #1;
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < N; i++) if (q[i].size() != 0) return 0;
    return 1;
  endfunction

  task automatic drain(input int budget, input string name);
    int n = 0;
    while ((!queues_empty() || m_busy) && n < budget) begin cycle(); n++; end
    check(name, (queues_empty() && !m_busy), 1);
  endtask

  task automatic wait_xfers(input int cnt, input int budget, input string name);
    int n = 0;
    while (x_log.size() < cnt && n < budget) begin cycle(); n++; end
    check(name, x_log.size() >= cnt, 1);
  endtask

  task automatic clear_logs();
    x_log.delete(); g_log.delete(); a_log.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0, c1, n0;
    int exp_own[6], exp_dat[6], exp_off[6];
    int gcnt[N];
    bit order_ok;

    reset = 1; req_valid = '0; req_last = '0; req_data = '0; tx_full = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_owner", owner, 0);
    check("reset_abort", abort_tick, 0);
    check("reset_wr", wr_uart, 0);
    check("reset_ready", req_ready, 0);
    model_reset();
    reset = 0;

    // Single packet from requester 0
    clear_logs();
    c0 = cyc;
    q[0] = '{{1'b0, 8'h41}, {1'b0, 8'h42}, {1'b1, 8'h43}};
    drain(50, "t1_drain");
    check("t1_nxfer", x_log.size(), 3);
    for (int k = 0; k < 3 && k < x_log.size(); k++) begin
      check("t1_data", x_log[k].dat, 8'h41 + k);
      check("t1_owner", x_log[k].own, 0);
      check("t1_cycle", x_log[k].cyc, c0 + 1 + k);
    end
    check("t1_grants", g_log.size(), 1);

    // Two simultaneous packets: atomic, one idle cycle between them
    clear_logs();
    c0 = cyc;
    q[1] = '{{1'b0, 8'h11}, {1'b0, 8'h12}, {1'b1, 8'h13}};
    q[2] = '{{1'b0, 8'h21}, {1'b0, 8'h22}, {1'b1, 8'h23}};
    drain(50, "t2_drain");
    exp_own = '{1, 1, 1, 2, 2, 2};
    exp_dat = '{8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23};
    exp_off = '{1, 2, 3, 5, 6, 7};
    check("t2_nxfer", x_log.size(), 6);
    for (int k = 0; k < 6 && k < x_log.size(); k++) begin
      check("t2_owner", x_log[k].own, exp_own[k]);
      check("t2_data", x_log[k].dat, exp_dat[k]);
      check("t2_cycle", x_log[k].cyc, c0 + exp_off[k]);
    end
    // Last served was 2, so 3 outranks 0
    clear_logs();
    q[0] = '{{1'b1, 8'h01}};
    q[3] = '{{1'b1, 8'h03}};
    drain(50, "t2b_drain");
    check("t2b_ngrant", g_log.size(), 2);
    if (g_log.size() == 2) begin
      check("t2b_first", g_log[0], 3);
      check("t2b_second", g_log[1], 0);
    end

    // Backpressure mid-packet must not trip the timeout
    clear_logs();
    q[2] = '{{1'b0, 8'h31}, {1'b0, 8'h32}, {1'b0, 8'h33}, {1'b1, 8'h34}};
    wait_xfers(1, 20, "t3_first_byte");
    force_full = 1;
    n0 = x_log.size();
    repeat (20) cycle();
    check("t3_no_wr_while_full", x_log.size(), n0);
    force_full = 0;
    drain(50, "t3_drain");
    check("t3_nxfer", x_log.size(), 4);
    for (int k = 0; k < 4 && k < x_log.size(); k++) check("t3_data", x_log[k].dat, 8'h31 + k);
    check("t3_no_abort", a_log.size(), 0);

    // Owner goes silent after one byte: evicted, pending requester 0 served next
    clear_logs();
    q[3] = '{{1'b0, 8'h5A}};
    wait_xfers(1, 20, "t4_first_byte");
    c1 = x_log[0].cyc;
    q[0] = '{{1'b1, 8'h60}};
    drain(60, "t4_drain");
    check("t4_abort_count", a_log.size(), 1);
    if (a_log.size() == 1) check("t4_abort_cycle", a_log[0], c1 + 17);
    check("t4_grants", g_log.size(), 2);
    if (g_log.size() == 2) check("t4_next_owner", g_log[1], 0);
    check("t4_nxfer", x_log.size(), 2);
    if (x_log.size() == 2) begin
      check("t4_next_data", x_log[1].dat, 8'h60);
      check("t4_next_cycle", x_log[1].cyc, c1 + 18);
    end

    // Reset in the cycle byte 2 of 4 is offered
    clear_logs();
    q[1] = '{{1'b0, 8'h71}, {1'b0, 8'h72}, {1'b0, 8'h73}, {1'b1, 8'h74}};
    wait_xfers(1, 20, "t5_first_byte");
    reset = 1;
    cycle();
    reset = 0;
    q[1].delete();
    check("t5_no_wr_in_reset", x_log.size(), 1);
    check("t5_busy_after", busy, 0);
    check("t5_owner_after", owner, 0);
    clear_logs();
    q[0] = '{{1'b1, 8'h0A}};
    q[3] = '{{1'b1, 8'h0D}};
    drain(50, "t5_drain");
    check("t5_ngrant", g_log.size(), 2);
    if (g_log.size() == 2) begin
      check("t5_first", g_log[0], 0);
      check("t5_second", g_log[1], 3);
    end

    // Everyone saturated: strict rotation
    clear_logs();
    for (int p = 0; p < 10; p++)
      for (int i = 0; i < N; i++) begin
        q[i].push_back({1'b0, 8'(i * 16 + p)});
        q[i].push_back({1'b1, 8'(i * 16 + p + 8)});
      end
    drain(400, "t6_drain");
    gcnt = '{0, 0, 0, 0};
    order_ok = (g_log.size() == 40);
    foreach (g_log[k]) begin
      if (g_log[k] >= 0 && g_log[k] < N) gcnt[g_log[k]]++;
      if (g_log[k] != k % N) order_ok = 0;
    end
    for (int i = 0; i < N; i++) check("t6_grant_count", gcnt[i], 10);
    check("t6_order", order_ok, 1);

    // Random traffic with drops, backpressure, unterminated packets and resets
    drop_pct = 25;
    full_pct = 30;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(19) == 0) begin
        int r, len;
        r = $urandom_range(N - 1);
        len = $urandom_range(5, 1);
        if (q[r].size() < 8)
          for (int b = 0; b < len; b++)
            q[r].push_back({(b == len - 1) && ($urandom_range(9) != 0), 8'($urandom_range(255))});
      end
      reset = ($urandom_range(399) == 0);
      cycle();
    end
    reset = 0;
    drop_pct = 0;
    full_pct = 0;
    drain(3000, "t7_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
